// File: rtl/staff_pixel_gen.sv
`default_nettype none
// ============================================================================
// staff_pixel_gen : five-line music staff renderer with a circular note table
//                   and a two-stage pixel classification pipeline.
// Revision        : 1.0 - initial release
// ============================================================================
module staff_pixel_gen #(
    parameter int NUM_SLOTS    = 16,
    parameter int SLOT_WIDTH   = 64,
    parameter int STAFF_TOP    = 200,
    parameter int LINE_SPACING = 16,
    parameter int HEAD_SIZE    = 12
) (
    input  logic        clk_pixel_in,
    input  logic        rst_n_in,
    input  logic [10:0] hcount_in,
    input  logic [9:0]  vcount_in,
    input  logic        active_draw_in,
    input  logic        new_frame_in,
    input  logic        note_valid_in,
    input  logic [6:0]  note_pitch_in,
    output logic        note_ready_out,
    input  logic        clear_in,
    output logic [1:0]  staff_pixel_out
);

    localparam int c_PTR_W  = $clog2(NUM_SLOTS);
    localparam int c_XOFF_W = $clog2(SLOT_WIDTH);
    localparam int c_IDX_W  = 11 - c_XOFF_W;

    localparam logic [c_IDX_W:0]       c_NUM_SLOTS_W = (c_IDX_W + 1)'(NUM_SLOTS);
    localparam logic [c_XOFF_W-1:0]    c_CURSOR_X    = c_XOFF_W'(2);
    localparam logic [c_PTR_W-1:0]     c_PTR_ONE     = c_PTR_W'(1);
    localparam logic [11:0]            c_STAFF_LO    = 12'(STAFF_TOP);
    localparam logic [11:0]            c_STAFF_HI    = 12'(STAFF_TOP + 4 * LINE_SPACING);
    localparam logic signed [13:0]     c_BASE_Y      = 14'(STAFF_TOP + 5 * LINE_SPACING);
    localparam logic signed [13:0]     c_HALF_LS     = 14'(LINE_SPACING / 2);
    localparam logic signed [13:0]     c_HALF_SW     = 14'(SLOT_WIDTH / 2);
    localparam logic signed [13:0]     c_HALF_HEAD   = 14'(HEAD_SIZE / 2);
    localparam logic signed [13:0]     c_NEG_HEAD    = -c_HALF_HEAD;

    // ------------------------------------------------------------------
    // Pitch to diatonic step (sharps fold onto the natural below)
    // ------------------------------------------------------------------
    logic [6:0] pitch_rel;
    logic [6:0] pitch_semi;
    logic [3:0] oct_base;
    logic [3:0] semi_step;
    logic       pitch_ok;
    logic [3:0] pend_step_d;

    always_comb begin
        pitch_ok   = (note_pitch_in >= 7'd60) && (note_pitch_in <= 7'd83);
        pitch_rel  = note_pitch_in - 7'd60;
        pitch_semi = pitch_rel;
        oct_base   = 4'd0;
        if (pitch_rel >= 7'd12) begin
            pitch_semi = pitch_rel - 7'd12;
            oct_base   = 4'd7;
        end
        case (pitch_semi[3:0])
            4'd0, 4'd1:  semi_step = 4'd0;
            4'd2, 4'd3:  semi_step = 4'd1;
            4'd4:        semi_step = 4'd2;
            4'd5, 4'd6:  semi_step = 4'd3;
            4'd7, 4'd8:  semi_step = 4'd4;
            4'd9, 4'd10: semi_step = 4'd5;
            default:     semi_step = 4'd6;
        endcase
        pend_step_d = oct_base + semi_step;
    end

    // ------------------------------------------------------------------
    // Pending note, clear flag and slot table
    // ------------------------------------------------------------------
    logic                 pend_valid_q;
    logic [3:0]           pend_step_q;
    logic                 clear_q;
    logic [c_PTR_W-1:0]   wr_ptr_q;
    logic [NUM_SLOTS-1:0] slot_valid_q;
    logic [3:0]           slot_step_q [NUM_SLOTS];

    assign note_ready_out = ~pend_valid_q;

    always_ff @(posedge clk_pixel_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            pend_valid_q <= 1'b0;
            pend_step_q  <= 4'd0;
            clear_q      <= 1'b0;
            wr_ptr_q     <= '0;
            slot_valid_q <= '0;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                slot_step_q[i] <= 4'd0;
            end
        end else begin
            if (clear_in) begin
                clear_q <= 1'b1;
            end
            // The table only moves at frame start so a frame is never torn.
            if (new_frame_in) begin
                if (clear_q || clear_in) begin
                    slot_valid_q <= '0;
                    wr_ptr_q     <= '0;
                    clear_q      <= 1'b0;
                    pend_valid_q <= 1'b0;
                end else if (pend_valid_q) begin
                    slot_valid_q[wr_ptr_q] <= 1'b1;
                    slot_step_q[wr_ptr_q]  <= pend_step_q;
                    wr_ptr_q               <= wr_ptr_q + c_PTR_ONE;
                    pend_valid_q           <= 1'b0;
                end
            end
            if (note_valid_in && !pend_valid_q && pitch_ok) begin
                pend_valid_q <= 1'b1;
                pend_step_q  <= pend_step_d;
            end
        end
    end

    // ------------------------------------------------------------------
    // Pixel stage 1
    // ------------------------------------------------------------------
    logic                line_hit_d;
    logic [c_IDX_W-1:0]  s1_idx_q;
    logic [c_XOFF_W-1:0] s1_xoff_q;
    logic [9:0]          s1_vcount_q;
    logic                s1_line_q;
    logic                s1_active_q;

    always_comb begin
        line_hit_d = 1'b0;
        for (int k = 0; k < 5; k++) begin
            if ({2'b00, vcount_in} == 12'(STAFF_TOP + k * LINE_SPACING)) begin
                line_hit_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_pixel_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            s1_idx_q    <= '0;
            s1_xoff_q   <= '0;
            s1_vcount_q <= '0;
            s1_line_q   <= 1'b0;
            s1_active_q <= 1'b0;
        end else begin
            s1_idx_q    <= hcount_in[10:c_XOFF_W];
            s1_xoff_q   <= hcount_in[c_XOFF_W-1:0];
            s1_vcount_q <= vcount_in;
            s1_line_q   <= line_hit_d;
            s1_active_q <= active_draw_in;
        end
    end

    // ------------------------------------------------------------------
    // Pixel stage 2
    // ------------------------------------------------------------------
    logic                     idx_in_range;
    logic [c_PTR_W-1:0]       slot_sel;
    logic [3:0]               sel_step;
    logic signed [13:0]       centre_y;
    logic signed [13:0]       dy;
    logic signed [13:0]       dx;
    logic                     note_hit;
    logic                     cursor_hit;
    logic [1:0]               pix_d;
    logic [1:0]               pix_q;

    always_comb begin
        idx_in_range = ({1'b0, s1_idx_q} < c_NUM_SLOTS_W);
        slot_sel     = s1_idx_q[c_PTR_W-1:0];
        sel_step     = slot_step_q[slot_sel];
        centre_y     = c_BASE_Y - ($signed({10'd0, sel_step}) * c_HALF_LS);
        dy           = $signed({4'd0, s1_vcount_q}) - centre_y;
        dx           = $signed({{(14 - c_XOFF_W){1'b0}}, s1_xoff_q}) - c_HALF_SW;
        note_hit     = idx_in_range && slot_valid_q[slot_sel]
                       && (dx > c_NEG_HEAD) && (dx < c_HALF_HEAD)
                       && (dy > c_NEG_HEAD) && (dy < c_HALF_HEAD);
        cursor_hit   = idx_in_range && (slot_sel == wr_ptr_q)
                       && (s1_xoff_q < c_CURSOR_X)
                       && ({2'b00, s1_vcount_q} >= c_STAFF_LO)
                       && ({2'b00, s1_vcount_q} <= c_STAFF_HI);
        pix_d = 2'd0;
        if (s1_active_q) begin
            if (note_hit) begin
                pix_d = 2'd2;
            end else if (cursor_hit) begin
                pix_d = 2'd3;
            end else if (s1_line_q) begin
                pix_d = 2'd1;
            end
        end
    end

    always_ff @(posedge clk_pixel_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            pix_q <= 2'd0;
        end else begin
            pix_q <= pix_d;
        end
    end

    assign staff_pixel_out = pix_q;

endmodule
`default_nettype wire

// File: tb/tb_staff_pixel_gen.sv
`default_nettype none
// ============================================================================
// tb_staff_pixel_gen : directed bench with a pixel scoreboard for staff_pixel_gen
// Revision           : 1.0 - initial release
// ============================================================================
module tb_staff_pixel_gen;

    logic        clk;
    logic        rst_n;
    logic [10:0] hcount;
    logic [9:0]  vcount;
    logic        active;
    logic        new_frame;
    logic        note_valid;
    logic [6:0]  note_pitch;
    logic        note_ready;
    logic        clear;
    logic [1:0]  pix;

    staff_pixel_gen dut (
        .clk_pixel_in    (clk),
        .rst_n_in        (rst_n),
        .hcount_in       (hcount),
        .vcount_in       (vcount),
        .active_draw_in  (active),
        .new_frame_in    (new_frame),
        .note_valid_in   (note_valid),
        .note_pitch_in   (note_pitch),
        .note_ready_out  (note_ready),
        .clear_in        (clear),
        .staff_pixel_out (pix)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_err = 0;
    int          cyc   = 0;
    logic [1:0]  exp_q [$];
    string       tag_q [$];
    int          due_q [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // One clock; then retire every scoreboard entry that is due this cycle.
    task automatic step();
        logic [1:0] e;
        string      t;
        @(posedge clk);
        #1;
        cyc++;
        while (due_q.size() > 0 && due_q[0] <= cyc) begin
            void'(due_q.pop_front());
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            chk(t, {30'd0, pix}, {30'd0, e});
        end
    endtask

    task automatic px(input int h, input int v, input logic a, input logic [1:0] e, input string tag);
        hcount = 11'(h);
        vcount = 10'(v);
        active = a;
        exp_q.push_back(e);
        tag_q.push_back(tag);
        due_q.push_back(cyc + 2);
        step();
    endtask

    task automatic drain();
        active = 1'b0;
        step();
        step();
    endtask

    task automatic frame();
        new_frame = 1'b1;
        step();
        new_frame = 1'b0;
    endtask

    task automatic offer(input int p);
        note_valid = 1'b1;
        note_pitch = 7'(p);
        step();
        note_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; hcount = '0; vcount = '0; active = 1'b1;
        new_frame = 1'b0; note_valid = 1'b0; note_pitch = '0; clear = 1'b0;
        vcount = 10'd200;
        step(); step();
        chk("reset_pix", {30'd0, pix}, 32'd0);
        chk("reset_ready", {31'd0, note_ready}, 32'd1);
        rst_n = 1'b1;
        step();

        // Empty staff: lines and cursor at slot 0
        px(100, 200, 1'b1, 2'd1, "empty_line200");
        px(0,   200, 1'b1, 2'd3, "empty_cursor_top");
        px(1,   220, 1'b1, 2'd3, "empty_cursor_x1");
        px(2,   220, 1'b1, 2'd0, "empty_x2_bg");
        px(32,  264, 1'b1, 2'd1, "empty_line264");
        px(32,  264, 1'b0, 2'd0, "empty_inactive");
        drain();

        // Single note, pitch 64 -> step 2, centre (32,264)
        offer(64);
        chk("ready_after_accept", {31'd0, note_ready}, 32'd0);
        px(32, 264, 1'b1, 2'd1, "pre_frame_no_note");
        drain();
        frame();
        chk("ready_after_commit", {31'd0, note_ready}, 32'd1);
        px(32,   264, 1'b1, 2'd2, "e4_head_centre");
        px(26,   264, 1'b1, 2'd1, "e4_x_edge_out");
        px(27,   264, 1'b1, 2'd2, "e4_x_edge_in");
        px(38,   264, 1'b1, 2'd1, "e4_x_right_out");
        px(32,   258, 1'b1, 2'd0, "e4_y_edge_out");
        px(32,   259, 1'b1, 2'd2, "e4_y_edge_in");
        px(64,   230, 1'b1, 2'd3, "cursor_slot1_x64");
        px(65,   230, 1'b1, 2'd3, "cursor_slot1_x65");
        px(66,   230, 1'b1, 2'd0, "cursor_slot1_x66");
        px(64,   199, 1'b1, 2'd0, "cursor_above_staff");
        px(64,   264, 1'b1, 2'd3, "cursor_over_line");
        px(32,   264, 1'b0, 2'd0, "note_inactive");
        px(1100, 216, 1'b1, 2'd1, "oob_slot_line");
        px(1088, 230, 1'b1, 2'd0, "oob_slot_no_cursor");
        drain();

        // Backpressure: 62 waits while 60 is pending
        note_valid = 1'b1; note_pitch = 7'd60;
        step();
        chk("bp_ready_low_60", {31'd0, note_ready}, 32'd0);
        note_pitch = 7'd62;
        step();
        chk("bp_ready_still_low", {31'd0, note_ready}, 32'd0);
        new_frame = 1'b1;
        step();
        new_frame = 1'b0;
        chk("bp_ready_after_frame", {31'd0, note_ready}, 32'd1);
        step();
        chk("bp_62_accepted", {31'd0, note_ready}, 32'd0);
        note_valid = 1'b0;
        frame();
        px(96,  280, 1'b1, 2'd2, "c4_slot1");
        px(160, 272, 1'b1, 2'd2, "d4_slot2");
        px(160, 280, 1'b1, 2'd0, "d4_not_at_c4");
        px(192, 240, 1'b1, 2'd3, "cursor_slot3");
        drain();

        // Out-of-range pitches are swallowed
        offer(59);
        chk("drop59_ready", {31'd0, note_ready}, 32'd1);
        offer(84);
        chk("drop84_ready", {31'd0, note_ready}, 32'd1);
        frame();
        px(192, 240, 1'b1, 2'd3, "drop_cursor_same");
        px(224, 264, 1'b1, 2'd1, "drop_slot3_empty");
        drain();

        // Clear with a pending note
        offer(65);
        clear = 1'b1;
        step();
        clear = 1'b0;
        px(32, 264, 1'b1, 2'd2, "clear_waits_frame");
        drain();
        frame();
        chk("clear_ready", {31'd0, note_ready}, 32'd1);
        px(100, 200, 1'b1, 2'd1, "clear_line200");
        px(32,  264, 1'b1, 2'd1, "clear_slot0_gone");
        px(96,  280, 1'b1, 2'd0, "clear_slot1_gone");
        px(0,   230, 1'b1, 2'd3, "clear_cursor0");
        px(64,  230, 1'b1, 2'd0, "clear_no_cursor1");
        drain();
        frame();
        px(96, 232, 1'b1, 2'd1, "clear_pending_dropped");
        drain();

        // 17 commits: 60..75 then 83 wraps into slot 0
        for (int i = 0; i < 17; i++) begin
            offer((i < 16) ? 60 + i : 83);
            frame();
        end
        px(64,  230, 1'b1, 2'd3, "wrap_cursor_x64");
        px(65,  230, 1'b1, 2'd3, "wrap_cursor_x65");
        px(0,   230, 1'b1, 2'd0, "wrap_no_cursor0");
        px(32,  176, 1'b1, 2'd2, "wrap_b5_slot0");
        px(32,  280, 1'b1, 2'd0, "wrap_old_c4_gone");
        px(992, 216, 1'b1, 2'd2, "wrap_slot15_ds5");
        px(480, 248, 1'b1, 2'd2, "wrap_slot7_g4");
        drain();

        // Asynchronous reset mid-line with a pending note
        offer(70);
        chk("prereset_ready", {31'd0, note_ready}, 32'd0);
        hcount = 11'd32; vcount = 10'd176; active = 1'b1;
        step(); step();
        chk("prereset_pix", {30'd0, pix}, 32'd2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset_pix", {30'd0, pix}, 32'd0);
        chk("async_reset_ready", {31'd0, note_ready}, 32'd1);
        step();
        rst_n = 1'b1;
        step();
        px(32, 176, 1'b1, 2'd0, "post_reset_no_note");
        px(0,  230, 1'b1, 2'd3, "post_reset_cursor0");
        px(32, 216, 1'b1, 2'd1, "post_reset_line");
        drain();
        frame();
        px(32, 240, 1'b1, 2'd0, "post_reset_pending_lost");
        drain();

        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
